pwm_fan_driver: RTL and testbench

- Downstream stage of the fuzzy logic controller. Consumes its 8-bit duty command `pw` and drives a single fan/motor PWM pin.
- Adds three things between the controller and the pin:
  - slew-limited duty ramping;
  - glitch-free duty updates, applied only at PWM period boundaries;
  - period/status outputs for observation.
- Runs on the 50 MHz system clock shared with the controller.

---
 rtl/fuzzy_pkg.sv | 38 +++
 rtl/pwm_prescaler.sv | 33 +++
 rtl/pwm_fan_driver.sv | 130 +++++++++++++
 tb/tb_pwm_fan_driver.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fuzzy_pkg.sv
// Shared definitions for the fuzzy controller output stage: PWM counter
// limits, fan driver state encoding and the duty slew helper.
package fuzzy_pkg;

    localparam int SYS_CLK_HZ = 50_000_000;
    localparam int DUTY_W     = 8;

    // Last count of the 255-step PWM period; the counter never shows 255,
    // so a duty of 255 keeps the pin high for the whole period.
    localparam logic [DUTY_W-1:0] PWM_CNT_TOP = 8'd254;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2,
        KICK = 2'd3
    } fan_state_t;

    // Move cur toward tgt by at most step; lands exactly on tgt when close.
    function automatic logic [DUTY_W-1:0] slew_step(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] tgt,
        input logic [DUTY_W-1:0] step
    );
        logic signed [DUTY_W:0] diff;
        logic signed [DUTY_W:0] lim;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        lim  = $signed({1'b0, step});
        if (diff > lim) begin
            return cur + step;
        end else if (diff < -lim) begin
            return cur - step;
        end else begin
            return tgt;
        end
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Divides the system clock down to the PWM count rate: one-clock tick
// every PRESCALE clocks (PRESCALE = 1 ticks on every clock).
module pwm_prescaler
    import fuzzy_pkg::*;
#(
    parameter int PRESCALE = 195
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    if (PRESCALE < 1 || PRESCALE > 65535 || PRESCALE * 255 > SYS_CLK_HZ) begin : g_bad_prescale
        $error("pwm_prescaler: PRESCALE out of range");
    end

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    logic [15:0] pre;

    assign tick = (pre == PRE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 16'd1;
        end
    end

endmodule

// File: rtl/pwm_fan_driver.sv
// Fan PWM stage after the fuzzy controller: slew-limited duty updated only at
// period boundaries. Define KICKSTART_EN for a full-on kick when starting from off.
module pwm_fan_driver
    import fuzzy_pkg::*;
#(
    parameter int PRESCALE     = 195,
    parameter int SLEW_STEP    = 4,
    parameter int KICK_PERIODS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DUTY_W-1:0]   pw,
    output logic                pwm_out,
    output logic [DUTY_W-1:0]   duty_cur,
    output logic                period_start,
    output logic                at_target,
    output logic [1:0]          fsm_state
);

    if (SLEW_STEP < 1 || SLEW_STEP > 255) begin : g_bad_slew
        $error("pwm_fan_driver: SLEW_STEP out of range");
    end
    if (KICK_PERIODS < 1 || KICK_PERIODS > 255) begin : g_bad_kick
        $error("pwm_fan_driver: KICK_PERIODS out of range");
    end

    localparam logic [DUTY_W-1:0] STEP = DUTY_W'(SLEW_STEP);

    logic               tick;
    logic               boundary;
    logic [DUTY_W-1:0]  cnt;
    logic [DUTY_W-1:0]  target;
    logic [DUTY_W-1:0]  step_duty;
    fan_state_t         state;

`ifdef KICKSTART_EN
    localparam int KW = $clog2(KICK_PERIODS + 1);
    localparam logic [KW-1:0] KICK_LAST = KW'(KICK_PERIODS);
    logic [KW-1:0] kick_cnt;
`endif

    pwm_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign boundary  = tick && (cnt == PWM_CNT_TOP);
    // The step is taken toward the value being sampled on this boundary edge.
    assign step_duty = slew_step(duty_cur, pw, STEP);
    assign fsm_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out      <= 1'b0;
            duty_cur     <= '0;
            period_start <= 1'b0;
            at_target    <= 1'b1;
            cnt          <= '0;
            target       <= '0;
            state        <= IDLE;
`ifdef KICKSTART_EN
            kick_cnt     <= '0;
`endif
        end else begin
            pwm_out      <= (cnt < duty_cur);
            at_target    <= (duty_cur == target);
            period_start <= boundary;

            if (tick) begin
                cnt <= boundary ? '0 : cnt + 8'd1;
            end

            if (boundary) begin
                target <= pw;
                case (state)
                    IDLE: begin
                        if (pw != '0) begin
`ifdef KICKSTART_EN
                            state    <= KICK;
                            duty_cur <= '1;
                            kick_cnt <= KW'(1);
`else
                            state    <= RAMP;
                            duty_cur <= step_duty;
`endif
                        end
                    end
                    RAMP: begin
                        duty_cur <= step_duty;
                        if (step_duty == pw) begin
                            state <= HOLD;
                        end
                    end
                    HOLD: begin
                        duty_cur <= step_duty;
                        if (step_duty == '0 && pw == '0) begin
                            state <= IDLE;
                        end else if (pw != target) begin
                            state <= RAMP;
                        end
                    end
`ifdef KICKSTART_EN
                    KICK: begin
                        // Dropping the demand to zero aborts into a normal ramp-down from full.
                        if (pw == '0) begin
                            state    <= RAMP;
                            duty_cur <= step_duty;
                            kick_cnt <= '0;
                        end else if (kick_cnt == KICK_LAST) begin
                            state    <= HOLD;
                            duty_cur <= pw;
                            kick_cnt <= '0;
                        end else begin
                            kick_cnt <= kick_cnt + KW'(1);
                        end
                    end
`endif
                    default: begin
                        state    <= IDLE;
                        duty_cur <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_fan_driver.sv
// Bench for pwm_fan_driver with PRESCALE = 1: vector table, corner sequences
// and random targets against a per-period behavioural model.
module tb_pwm_fan_driver;
  import fuzzy_pkg::*;

  localparam int PRESCALE = 1;
  localparam int S        = 4;
  localparam int KP       = 16;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pw  = 8'd0;
  logic       pwm_out;
  logic [7:0] duty_cur;
  logic       period_start;
  logic       at_target;
  logic [1:0] fsm_state;

  always #5 clk = ~clk;

  pwm_fan_driver #(
    .PRESCALE     (PRESCALE),
    .SLEW_STEP    (S),
    .KICK_PERIODS (KP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pw           (pw),
    .pwm_out      (pwm_out),
    .duty_cur     (duty_cur),
    .period_start (period_start),
    .at_target    (at_target),
    .fsm_state    (fsm_state)
  );

  int errors = 0;
  int checks = 0;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // reference model: duty per period, expected high time per period
  int         m_duty   = 0;
  int         m_target = 0;
  int         hi_cnt   = 0;
  int         per_len  = 0;
  logic [7:0] pw_edge  = 8'd0;
  logic [7:0] exp_q[$];
`ifdef KICKSTART_EN
  int         m_phase  = 0;  // 0 off, 1 moving, 2 settled, 3 kicking
  int         m_kick   = 0;
`endif

  function automatic int slew(input int d, input int t);
    int diff;
    diff = t - d;
    if (diff > S) return d + S;
    if (diff < -S) return d - S;
    return t;
  endfunction

  function automatic void model_boundary(input int t);
`ifdef KICKSTART_EN
    case (m_phase)
      0: if (t != 0) begin m_phase = 3; m_kick = 1; m_duty = 255; end
      3: begin
        if (t == 0) begin m_phase = 1; m_duty = slew(m_duty, 0); end
        else if (m_kick == KP) begin m_phase = 2; m_duty = t; end
        else m_kick++;
      end
      default: begin
        m_duty = slew(m_duty, t);
        if (m_phase == 1) begin
          if (m_duty == t) m_phase = 2;
        end else begin
          if (m_duty == 0 && t == 0) m_phase = 0;
          else if (t != m_target) m_phase = 1;
        end
      end
    endcase
`else
    m_duty = slew(m_duty, t);
`endif
    m_target = t;
  endfunction

  always @(posedge clk) pw_edge = pw;

  // scoreboard
  always @(negedge clk) begin
    if (rst) begin
      m_duty = 0; m_target = 0; hi_cnt = 0; per_len = 0;
`ifdef KICKSTART_EN
      m_phase = 0; m_kick = 0;
`endif
      exp_q.delete();
      exp_q.push_back(8'd0);
    end else begin
      per_len++;
      hi_cnt += int'(pwm_out);
      if (period_start) begin
        check("period_len", per_len, 255 * PRESCALE);
        check("high_time", hi_cnt, int'(exp_q.pop_front()));
        check("at_target_prev", int'(at_target), int'(m_duty == m_target));
        model_boundary(int'(pw_edge));
        exp_q.push_back(8'(m_duty));
        hi_cnt = 0;
        per_len = 0;
      end
      check("duty_cur", int'(duty_cur), m_duty);
    end
  end

  // driver tasks
  task automatic wait_periods(input int n);
    int guard;
    for (int i = 0; i < n; i++) begin
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (!period_start && guard < 600);
      if (!period_start) begin
        checks++;
        errors++;
        $display("FAIL period_timeout: got no period_start within %0d clocks expected one", guard);
        return;
      end
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  typedef struct {
    logic [7:0] pw;
    int         periods;
    int         exp_duty;
    int         exp_state;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'd200, 1,  4,   int'(RAMP)};
    vecs[1] = '{8'd200, 1,  8,   int'(RAMP)};
    vecs[2] = '{8'd200, 48, 200, int'(HOLD)};
    vecs[3] = '{8'd255, 16, 255, int'(HOLD)};
    vecs[4] = '{8'd0,   66, 0,   int'(IDLE)};
    vecs[5] = '{8'd6,   1,  4,   int'(RAMP)};
    vecs[6] = '{8'd6,   1,  6,   int'(HOLD)};
    vecs[7] = '{8'd100, 25, 100, int'(HOLD)};

    rst = 1'b1;
    pw  = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_pwm_out", int'(pwm_out), 0);
    check("rst_duty_cur", int'(duty_cur), 0);
    check("rst_period_start", int'(period_start), 0);
    check("rst_at_target", int'(at_target), 1);
    check("rst_state", int'(fsm_state), int'(IDLE));
    #2 rst = 1'b0;

`ifndef KICKSTART_EN
    foreach (vecs[i]) begin
      pw = vecs[i].pw;
      wait_periods(vecs[i].periods);
      check($sformatf("vec%0d_duty", i), int'(duty_cur), vecs[i].exp_duty);
      check($sformatf("vec%0d_state", i), int'(fsm_state), vecs[i].exp_state);
      @(negedge clk);
      check($sformatf("vec%0d_at_target", i), int'(at_target),
            int'(vecs[i].exp_duty == int'(vecs[i].pw)));
    end

    // target change in the middle of a period waits for the next boundary
    wait_periods(1);
    repeat (50) @(negedge clk);
    pw = 8'd10;
    repeat (100) @(negedge clk);
    check("mid_period_hold", int'(duty_cur), 100);
    wait_periods(1);
    check("mid_period_step", int'(duty_cur), 96);
    check("mid_period_state", int'(fsm_state), int'(RAMP));

    // asynchronous reset mid-ramp
    pulse_reset();
    pw = 8'd200;
    wait_periods(10);
    check("ramp_at_40", int'(duty_cur), 40);
    repeat (5) @(negedge clk);
    check("pwm_high_before_rst", int'(pwm_out), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pwm_out", int'(pwm_out), 0);
    check("async_rst_duty_cur", int'(duty_cur), 0);
    check("async_rst_at_target", int'(at_target), 1);
    check("async_rst_state", int'(fsm_state), int'(IDLE));
    @(negedge clk);
    #2 rst = 1'b0;
    wait_periods(1);
    check("restart_duty_1", int'(duty_cur), 4);
    wait_periods(1);
    check("restart_duty_2", int'(duty_cur), 8);
`else
    // kick-start from off, then abort of a second kick
    pw = 8'd60;
    for (int i = 0; i < KP; i++) begin
      wait_periods(1);
      check($sformatf("kick_duty_%0d", i), int'(duty_cur), 255);
    end
    check("kick_state", int'(fsm_state), int'(KICK));
    wait_periods(1);
    check("kick_exit_duty", int'(duty_cur), 60);
    check("kick_exit_state", int'(fsm_state), int'(HOLD));
    @(negedge clk);
    check("kick_exit_at_target", int'(at_target), 1);
    pw = 8'd0;
    wait_periods(17);
    check("kick_off_duty", int'(duty_cur), 0);
    check("kick_off_state", int'(fsm_state), int'(IDLE));
    pw = 8'd60;
    wait_periods(5);
    check("kick2_duty", int'(duty_cur), 255);
    pw = 8'd0;
    wait_periods(1);
    check("kick_abort_1", int'(duty_cur), 251);
    check("kick_abort_state", int'(fsm_state), int'(RAMP));
    wait_periods(1);
    check("kick_abort_2", int'(duty_cur), 247);
`endif

    // random targets, changed at random points within a period
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 250)) @(negedge clk);
      pw = 8'($urandom_range(0, 255));
      wait_periods($urandom_range(1, 3));
    end
    wait_periods(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
